can_reg_read_port: RTL and testbench
====================================

Name: can_reg_read_port

Overview:
- Host-side read engine for the CAN controller register bank; the read counterpart of the write-enabled register cells.
- Detects a host read strobe and selects one register from the flattened register bus.
- Returns the selected value with a level acknowledge.
- Issues a one-cycle clear pulse when the interrupt register is read (clear-on-read).

Parameters:
- WIDTH, 8, register width in bits.
- NUM_REGS, 32, number of readable registers on reg_bus.
- ADDR_W, 8, host address width.
- IR_ADDR, 3, address of the clear-on-read interrupt register.
- OOR_VALUE, 8'hFF, value returned for addresses >= NUM_REGS.
- U_DLY, 1, simulation delay on registered assignments.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- cs  input  1  host chip select.
- rd  input  1  host read strobe; read request level is cs&rd.
- addr  input  ADDR_W  register address; sampled in LATCH.
- reg_bus  input  NUM_REGS*WIDTH  register values; register k is reg_bus[k*WIDTH +: WIDTH].
- data_out  output  WIDTH  read data, registered.
- rd_ack  output  1  read data valid; level, held until request drops.
- ir_clr  output  1  one-cycle pulse; clears the interrupt register.
- rd_err  output  1  set with rd_ack when the address was out of range.

Behaviour:
- Reset and outputs
  - All logic is synchronous to posedge clk, with reset synchronous and active-high.
  - rst=1 on an edge forces: state=IDLE, data_out=0, rd_ack=0, ir_clr=0, rd_err=0, req_d=0.
  - Reset overrides everything, including mid-transaction: an ack in progress drops on the reset edge, and no ir_clr is issued.
- Request detection
  - req = cs&rd; req_d is req registered every cycle.
  - start = req & ~req_d (rising edge). A request held high from before reset release counts as a start, because req_d=0 after reset.
- FSM, 3 states:
  - IDLE: if start, go to LATCH. Otherwise stay, with outputs holding their values except ir_clr=0.
  - LATCH: capture addr.
    - If addr<NUM_REGS: data_out<=reg_bus slice and rd_err<=0.
    - Else: data_out<=OOR_VALUE and rd_err<=1.
    - rd_ack<=1.
    - ir_clr<=1 only if addr==IR_ADDR and IR_ADDR<NUM_REGS.
    - Always go to HOLD, even if req has dropped.
  - HOLD: ir_clr<=0. If req=0: rd_ack<=0, rd_err<=0, go to IDLE. Otherwise stay, with data_out frozen; reg_bus changes are not tracked.
- Latency
  - start seen at edge N, so LATCH occupies cycle N..N+1.
  - data_out, rd_ack and ir_clr are valid after edge N+1, i.e. 2 clocks from the rising req.
  - ir_clr lasts exactly 1 cycle.
- Early drop: if req falls during LATCH, the transaction still completes. rd_ack is high for 1 cycle, then falls in HOLD on the next edge.
- Back-to-back: a new start is accepted only from IDLE. A rising req while in HOLD is impossible, since req must fall to leave HOLD.
- Min cycle: req high 1 clk, then low, then high again gives 2 accepted reads provided ≥1 low cycle is observed in IDLE.
- data_out keeps the last read value after rd_ack falls, until the next LATCH or reset.
- addr is ignored outside LATCH. Address wrap is not applied: any addr ≥ NUM_REGS is out of range.
- ir_clr is asserted only once per transaction, even if req is held high for many cycles.

Test Plan:
1. Reset: hold rst=1 for 3 clk with cs=rd=1 → data_out=0, rd_ack=0, ir_clr=0. Release rst with req still high → a read starts (req_d=0), and rd_ack=1 two clocks later.
2. Basic read: reg 5 = 8'hA5, addr=5, raise cs&rd at edge N → data_out=8'hA5 and rd_ack=1 after edge N+1, rd_err=0, ir_clr=0. Hold req 4 clk → values stable. Drop req → rd_ack=0 next edge, data_out stays 8'hA5.
3. Clear-on-read: addr=3 (IR_ADDR), reg 3 = 8'h0C → data_out=8'h0C and ir_clr=1 for exactly one cycle, coincident with the rd_ack rise. Hold req 10 clk → no second pulse.
4. Out of range: addr=40 → data_out=8'hFF, rd_err=1, rd_ack=1. Drop req → rd_err=0 and rd_ack=0 together.
5. Early drop and frozen data: req high for 1 clk only, addr=7 → rd_ack high for exactly 1 cycle. Separately, change reg 7 from 8'h11 to 8'h22 during HOLD → data_out stays 8'h11.
6. Reset mid-read: assert rst in the LATCH cycle at addr=3 → no ir_clr pulse, rd_ack=0, state IDLE. Then a normal read of addr=3 → one ir_clr pulse.

Source files
------------

// File: rtl/can_reg_read_port.sv
// rtl/can_reg_read_port.sv - host read engine for the CAN register bank with clear-on-read pulse
module can_reg_read_port #(
  parameter int              WIDTH     = 8,
  parameter int              NUM_REGS  = 32,
  parameter int              ADDR_W    = 8,
  parameter int              IR_ADDR   = 3,
  parameter logic [WIDTH-1:0] OOR_VALUE = WIDTH'(8'hFF),
  parameter int              U_DLY     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cs,
  input  logic                      rd,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [NUM_REGS*WIDTH-1:0] reg_bus,
  output logic [WIDTH-1:0]          data_out,
  output logic                      rd_ack,
  output logic                      ir_clr,
  output logic                      rd_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;
  logic   req;
  logic   req_d;
  logic   start;
  logic   in_range;
  logic   ir_hit;
  logic [WIDTH-1:0] sel_data;

  // Registered assignments are zero-delay here; the delay parameter is kept for
  // drop-in compatibility with the write-side register cells.
  logic unused_dly;
  assign unused_dly = |U_DLY;

  assign req   = cs & rd;
  assign start = req & ~req_d;

  // No address wrap: anything at or beyond NUM_REGS is out of range.
  assign in_range = (32'(addr) < NUM_REGS);
  assign ir_hit   = (32'(addr) == IR_ADDR) && (IR_ADDR < NUM_REGS);

  // Register selection mux over the flattened bus; OOR_VALUE when no slice matches.
  always_comb begin
    sel_data = OOR_VALUE;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (32'(addr) == k) begin
        sel_data = reg_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Request edge tracking and read FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_d    <= 1'b0;
      data_out <= '0;
      rd_ack   <= 1'b0;
      ir_clr   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      req_d <= req;
      case (state)
        IDLE: begin
          ir_clr <= 1'b0;
          if (start) begin
            state <= LATCH;
          end
        end
        LATCH: begin
          // Completes even if the request already dropped, so the host always
          // sees at least one cycle of rd_ack per accepted start.
          data_out <= sel_data;
          rd_err   <= ~in_range;
          rd_ack   <= 1'b1;
          ir_clr   <= ir_hit;
          state    <= HOLD;
        end
        HOLD: begin
          // data_out stays frozen here; later reg_bus changes are not tracked.
          ir_clr <= 1'b0;
          if (!req) begin
            rd_ack <= 1'b0;
            rd_err <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_reg_read_port.sv
// tb/tb_can_reg_read_port.sv - randomized self-checking bench for can_reg_read_port
module tb_can_reg_read_port;

  localparam int WIDTH    = 8;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 8;
  localparam int IR_ADDR  = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      cs;
  logic                      rd;
  logic [ADDR_W-1:0]         addr;
  logic [NUM_REGS*WIDTH-1:0] reg_bus;
  logic [WIDTH-1:0]          data_out;
  logic                      rd_ack;
  logic                      ir_clr;
  logic                      rd_err;

  logic [WIDTH-1:0] regs [NUM_REGS];

  int checks = 0;
  int errors = 0;

  can_reg_read_port #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .IR_ADDR  (IR_ADDR),
    .OOR_VALUE(8'hFF),
    .U_DLY    (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .rd      (rd),
    .addr    (addr),
    .reg_bus (reg_bus),
    .data_out(data_out),
    .rd_ack  (rd_ack),
    .ir_clr  (ir_clr),
    .rd_err  (rd_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_bus[k*WIDTH +: WIDTH] = regs[k];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference rules: value a host should see for a given address.
  function automatic logic [WIDTH-1:0] model_data(input int a);
    if (a < NUM_REGS) return regs[a];
    return 8'hFF;
  endfunction

  // One full host read transaction; h = number of edges the request stays high
  // starting from the edge that detects it.
  task automatic do_read(input int a, input int h, input bit mutate, input string tag);
    logic [WIDTH-1:0] ed;
    logic ee;
    logic ei;
    ed = model_data(a);
    ee = (a >= NUM_REGS);
    ei = (a == IR_ADDR);
    addr = ADDR_W'(a);
    cs = 1'b1;
    rd = 1'b1;
    tick;
    checks++; if (rd_ack !== 1'b0 || ir_clr !== 1'b0) begin errors++; $display("FAIL %s early_ack ack=%b ir=%b required 0 0", tag, rd_ack, ir_clr); end
    if (h == 1) begin
      if ($urandom_range(0, 1) == 0) cs = 1'b0; else rd = 1'b0;
    end
    tick;
    checks++; if (data_out !== ed) begin errors++; $display("FAIL %s data got=%h required=%h", tag, data_out, ed); end
    checks++; if (rd_ack !== 1'b1) begin errors++; $display("FAIL %s ack_rise got=%b required=1", tag, rd_ack); end
    checks++; if (rd_err !== ee) begin errors++; $display("FAIL %s err got=%b required=%b", tag, rd_err, ee); end
    checks++; if (ir_clr !== ei) begin errors++; $display("FAIL %s ir_clr got=%b required=%b", tag, ir_clr, ei); end
    addr = ADDR_W'($urandom);
    if (mutate && a < NUM_REGS) regs[a] = regs[a] + 8'h11;
    if (h >= 2) begin
      for (int i = 0; i < h - 2; i++) begin
        tick;
        checks++; if (rd_ack !== 1'b1 || ir_clr !== 1'b0 || rd_err !== ee || data_out !== ed) begin
          errors++; $display("FAIL %s hold ack=%b ir=%b err=%b data=%h required 1 0 %b %h", tag, rd_ack, ir_clr, rd_err, data_out, ee, ed);
        end
      end
      if ($urandom_range(0, 1) == 0) cs = 1'b0; else rd = 1'b0;
    end
    tick;
    checks++; if (rd_ack !== 1'b0 || rd_err !== 1'b0 || ir_clr !== 1'b0) begin
      errors++; $display("FAIL %s drop ack=%b err=%b ir=%b required 0 0 0", tag, rd_ack, rd_err, ir_clr);
    end
    checks++; if (data_out !== ed) begin errors++; $display("FAIL %s data_kept got=%h required=%h", tag, data_out, ed); end
  endtask

  task automatic test_reset;
    regs[5] = 8'h5A;
    addr = 8'd5;
    rst = 1'b1;
    cs = 1'b1;
    rd = 1'b1;
    repeat (3) tick;
    checks++; if (data_out !== 8'h00 || rd_ack !== 1'b0 || ir_clr !== 1'b0 || rd_err !== 1'b0) begin
      errors++; $display("FAIL reset data=%h ack=%b ir=%b err=%b required 00 0 0 0", data_out, rd_ack, ir_clr, rd_err);
    end
    rst = 1'b0;
    tick;
    checks++; if (rd_ack !== 1'b0) begin errors++; $display("FAIL reset_latch ack got=%b required=0", rd_ack); end
    tick;
    checks++; if (rd_ack !== 1'b1 || data_out !== 8'h5A) begin
      errors++; $display("FAIL reset_start ack=%b data=%h required 1 5a", rd_ack, data_out);
    end
    cs = 1'b0;
    rd = 1'b0;
    tick;
    checks++; if (rd_ack !== 1'b0) begin errors++; $display("FAIL reset_drop ack got=%b required=0", rd_ack); end
  endtask

  task automatic test_basic;
    regs[5] = 8'hA5;
    do_read(5, 6, 0, "basic");
  endtask

  task automatic test_clear_on_read;
    regs[3] = 8'h0C;
    do_read(3, 12, 0, "clr_on_read");
  endtask

  task automatic test_out_of_range;
    do_read(40, 3, 0, "oor40");
    do_read(32, 2, 0, "oor32");
    do_read(31, 2, 0, "last_reg");
    do_read(255, 2, 0, "oor255");
  endtask

  task automatic test_early_drop;
    regs[7] = 8'h11;
    do_read(7, 1, 0, "early_drop");
    do_read(7, 5, 1, "frozen");
    checks++; if (regs[7] !== 8'h22 || data_out !== 8'h11) begin
      errors++; $display("FAIL frozen_final data=%h required=11", data_out);
    end
  endtask

  task automatic test_reset_mid;
    regs[3] = 8'h0C;
    do_read(9, 2, 0, "pre_mid");
    addr = 8'd3;
    cs = 1'b1;
    rd = 1'b1;
    tick;
    rst = 1'b1;
    tick;
    checks++; if (ir_clr !== 1'b0 || rd_ack !== 1'b0 || data_out !== 8'h00 || rd_err !== 1'b0) begin
      errors++; $display("FAIL reset_mid ir=%b ack=%b data=%h err=%b required 0 0 00 0", ir_clr, rd_ack, data_out, rd_err);
    end
    rst = 1'b0;
    cs = 1'b0;
    rd = 1'b0;
    tick;
    tick;
    checks++; if (ir_clr !== 1'b0 || rd_ack !== 1'b0) begin
      errors++; $display("FAIL reset_mid_idle ir=%b ack=%b required 0 0", ir_clr, rd_ack);
    end
    do_read(3, 4, 0, "post_mid");
  endtask

  task automatic test_random;
    int a;
    int sel;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) a = $urandom_range(NUM_REGS, 255);
      else if (sel == 2) a = IR_ADDR;
      else a = $urandom_range(0, NUM_REGS - 1);
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, NUM_REGS - 1)] = 8'($urandom);
      do_read(a, $urandom_range(1, 6), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    for (int k = 0; k < NUM_REGS; k++) regs[k] = 8'($urandom);
    rst = 1'b1;
    cs = 1'b0;
    rd = 1'b0;
    addr = '0;
    test_reset;
    test_basic;
    test_clear_on_read;
    test_out_of_range;
    test_early_drop;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
